// File: rtl/mdio_slave_if.sv
// rtl/mdio_slave_if.sv - Clause 22 MDIO slave decoding oversampled MDC/MDIO into regfile strobes
module mdio_slave_if #(
    parameter logic [4:0]  PHY_ADDR = 5'h01,
    parameter int unsigned PRE_LEN  = 32
) (
    input  logic        clk_200m,
    input  logic        rstn_200m,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PRE_LEN);

    state_t      state_q, state_d;
    logic [1:0]  mdc_sync_q, mdio_sync_q;
    logic        mdc_prev_q;
    logic        rise, bit_in, drive_rd;
    logic [4:0]  shifted5;

    logic [5:0]  ones_cnt_q, ones_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  addr_sh_q, addr_sh_d;
    logic        is_read_q, is_read_d;
    logic        match_q, match_d;
    logic        rd_dly_q, rd_dly_d;
    logic [15:0] shift_q, shift_d;

    logic        mdio_out_q, mdio_out_d;
    logic        mdio_oen_q, mdio_oen_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic        reg_rd_en_q, reg_rd_en_d;

    // Two-flop synchronisers for the pad nets plus the previous MDC level for edge detect
    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            mdc_sync_q  <= 2'b00;
            mdio_sync_q <= 2'b00;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[0], mdc};
            mdio_sync_q <= {mdio_sync_q[0], mdio_in};
            mdc_prev_q  <= mdc_sync_q[1];
        end
    end

    assign rise     = mdc_sync_q[1] & ~mdc_prev_q;
    assign bit_in   = mdio_sync_q[1];
    assign drive_rd = is_read_q & match_q;
    assign shifted5 = {addr_sh_q[3:0], bit_in};

    // Frame state register and all datapath/output registers
    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            state_q     <= S_IDLE;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            addr_sh_q   <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            rd_dly_q    <= 1'b0;
            shift_q     <= '0;
            mdio_out_q  <= 1'b0;
            mdio_oen_q  <= 1'b1;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sh_q   <= addr_sh_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            rd_dly_q    <= rd_dly_d;
            shift_q     <= shift_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oen_q  <= mdio_oen_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_en_q <= reg_wr_en_d;
            reg_rd_en_q <= reg_rd_en_d;
        end
    end

    // Next-state decode; everything advances on MDC rise except the read-data latch
    always_comb begin
        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        addr_sh_d   = addr_sh_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        rd_dly_d    = reg_rd_en_q;
        shift_d     = shift_q;
        mdio_out_d  = mdio_out_q;
        mdio_oen_d  = mdio_oen_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_en_d = 1'b0;
        reg_rd_en_d = 1'b0;

        // Regfile answers one cycle after the read strobe
        if (rd_dly_q) begin
            shift_d = reg_rdata;
        end

        if (rise) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        if (ones_cnt_q != 6'd63) begin
                            ones_cnt_d = ones_cnt_q + 6'd1;
                        end
                    end else if (ones_cnt_q >= PRE_MIN) begin
                        // Count is spent once ST starts so every frame needs its own preamble
                        state_d    = S_ST;
                        ones_cnt_d = '0;
                    end else begin
                        ones_cnt_d = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = '0;
                    if (bit_in) begin
                        state_d = S_OP;
                    end else begin
                        state_d    = S_IDLE;
                        ones_cnt_d = '0;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        addr_sh_d = {4'b0000, bit_in};
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        case ({addr_sh_q[0], bit_in})
                            2'b01: begin
                                is_read_d = 1'b0;
                                state_d   = S_PHYAD;
                            end
                            2'b10: begin
                                is_read_d = 1'b1;
                                state_d   = S_PHYAD;
                            end
                            default: begin
                                state_d    = S_IDLE;
                                ones_cnt_d = '0;
                            end
                        endcase
                    end
                end
                S_PHYAD: begin
                    addr_sh_d = shifted5;
                    if (bit_cnt_q == 4'd4) begin
                        match_d   = (shifted5 == PHY_ADDR);
                        bit_cnt_d = '0;
                        state_d   = S_REGAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_REGAD: begin
                    addr_sh_d = shifted5;
                    if (bit_cnt_q == 4'd4) begin
                        reg_addr_d  = shifted5;
                        reg_rd_en_d = drive_rd;
                        bit_cnt_d   = '0;
                        state_d     = S_TA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        if (drive_rd) begin
                            mdio_oen_d = 1'b0;
                            mdio_out_d = 1'b0;
                        end
                        bit_cnt_d = 4'd1;
                    end else begin
                        // Present D15 now so the master sees it at the first DATA rise
                        if (drive_rd) begin
                            mdio_out_d = shift_q[15];
                            shift_d    = {shift_q[14:0], 1'b0};
                        end
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (is_read_q) begin
                        if (bit_cnt_q == 4'd15) begin
                            mdio_oen_d = 1'b1;
                            mdio_out_d = 1'b0;
                        end else if (match_q) begin
                            mdio_out_d = shift_q[15];
                            shift_d    = {shift_q[14:0], 1'b0};
                        end
                    end else begin
                        shift_d = {shift_q[14:0], bit_in};
                    end
                    if (bit_cnt_q == 4'd15) begin
                        if (!is_read_q && match_q) begin
                            reg_wdata_d = {shift_q[14:0], bit_in};
                            reg_wr_en_d = 1'b1;
                        end
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    ones_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr_en = reg_wr_en_q;
    assign reg_rd_en = reg_rd_en_q;

endmodule

// File: tb/tb_mdio_slave_if.sv
// tb/tb_mdio_slave_if.sv - randomized frame-level checking of mdio_slave_if against a behavioural model
module tb_mdio_slave_if;

    localparam logic [4:0] PHY = 5'h01;
    localparam int         PRE = 32;

    logic        clk_200m  = 1'b0;
    logic        rstn_200m = 1'b0;
    logic        mdc       = 1'b0;
    logic        mdio_in   = 1'b1;
    logic        mdio_out;
    logic        mdio_oen;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [15:0] reg_rdata = 16'h0000;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [32];
    int          ev_kind_q [$];
    logic [4:0]  ev_addr_q [$];
    logic [15:0] ev_data_q [$];
    logic        bus_may_drive = 1'b0;
    int          garble = 0;
    logic        s_oen [32];
    logic        s_out [32];
    int          last_n_wr;
    int          last_n_rd;
    logic [4:0]  last_wr_addr;
    logic [15:0] last_wr_data;
    logic [15:0] rd_word;

    mdio_slave_if #(.PHY_ADDR(PHY), .PRE_LEN(PRE)) dut (
        .clk_200m  (clk_200m),
        .rstn_200m (rstn_200m),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata)
    );

    always #5 clk_200m = ~clk_200m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare: strobe capture, regfile answer, and bus idle whenever no read may drive
    always @(negedge clk_200m) begin
        if (garble > 0) begin
            garble--;
            if (garble == 0) reg_rdata = 16'($urandom);
        end
        if (reg_wr_en || reg_rd_en) begin
            check("strobe_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
            if (reg_wr_en) begin
                ev_kind_q.push_back(1);
                ev_addr_q.push_back(reg_addr);
                ev_data_q.push_back(reg_wdata);
            end
            if (reg_rd_en) begin
                ev_kind_q.push_back(2);
                ev_addr_q.push_back(reg_addr);
                ev_data_q.push_back(16'h0000);
                reg_rdata = mem[reg_addr];
                garble    = 2;
            end
        end
        if (!bus_may_drive) check("bus_idle", 32'({mdio_oen, mdio_out}), 32'd2);
    end

    // One MDC period: data changes in the low phase, master samples the slave just before rising
    task automatic send_bit(input logic b, input int idx, input logic drive_frame);
        mdio_in = b;
        repeat ($urandom_range(4, 6)) @(negedge clk_200m);
        if (idx >= 0) begin
            s_oen[idx] = mdio_oen;
            s_out[idx] = mdio_out;
        end
        if (idx == 14 && drive_frame) bus_may_drive = 1'b1;
        mdc = 1'b1;
        repeat ($urandom_range(4, 6)) @(negedge clk_200m);
        mdc = 1'b0;
    endtask

    task automatic frame(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
        logic [31:0] body;
        logic        wr_exp, rd_exp, hdr_drive, data_all_low, data_any_low;
        int          n_wr, n_rd, wi, ri;
        wr_exp = (pre_n >= PRE) && (op == 2'b01) && (phy == PHY);
        rd_exp = (pre_n >= PRE) && (op == 2'b10) && (phy == PHY);
        body   = {2'b01, op, phy, ra, (op == 2'b10) ? 2'b11 : 2'b10, (op == 2'b10) ? 16'hFFFF : wd};
        ev_kind_q.delete();
        ev_addr_q.delete();
        ev_data_q.delete();
        rd_word = 16'h0000;
        send_bit(1'b0, -1, 1'b0);
        for (int i = 0; i < pre_n; i++) send_bit(1'b1, -1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            send_bit(body[31-i], i, rd_exp);
            if (i == abort_at) begin
                repeat (3) @(negedge clk_200m);
                check("abort_pre_drive", 32'(mdio_oen), 32'd0);
                #1 rstn_200m = 1'b0;
                #1;
                check("abort_oen", 32'(mdio_oen), 32'd1);
                check("abort_out", 32'(mdio_out), 32'd0);
                check("abort_addr", 32'(reg_addr), 32'd0);
                check("abort_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
                repeat (3) @(negedge clk_200m);
                rstn_200m     = 1'b1;
                bus_may_drive = 1'b0;
                ev_kind_q.delete();
                ev_addr_q.delete();
                ev_data_q.delete();
                return;
            end
        end
        repeat (10) @(negedge clk_200m);
        bus_may_drive = 1'b0;
        check("post_frame_release", 32'({mdio_oen, mdio_out}), 32'd2);
        hdr_drive = 1'b0;
        for (int i = 0; i < 15; i++) if (!s_oen[i]) hdr_drive = 1'b1;
        check("hdr_no_drive", 32'(hdr_drive), 32'd0);
        data_all_low = 1'b1;
        data_any_low = 1'b0;
        for (int i = 15; i < 32; i++) begin
            if (s_oen[i]) data_all_low = 1'b0;
            else data_any_low = 1'b1;
        end
        for (int k = 0; k < 16; k++) rd_word[15-k] = s_out[16+k];
        if (rd_exp) begin
            check("rd_oen_window", 32'(data_all_low), 32'd1);
            check("rd_ta2_out", 32'(s_out[15]), 32'd0);
            check("rd_data", 32'(rd_word), 32'(mem[ra]));
        end else begin
            check("no_drive", 32'(data_any_low), 32'd0);
        end
        n_wr = 0;
        n_rd = 0;
        wi   = -1;
        ri   = -1;
        foreach (ev_kind_q[e]) begin
            if (ev_kind_q[e] == 1) begin n_wr++; wi = e; end
            else begin n_rd++; ri = e; end
        end
        check("wr_count", 32'(n_wr), 32'(wr_exp));
        check("rd_count", 32'(n_rd), 32'(rd_exp));
        if (wr_exp && wi >= 0) begin
            check("wr_addr", 32'(ev_addr_q[wi]), 32'(ra));
            check("wr_data", 32'(ev_data_q[wi]), 32'(wd));
            last_wr_addr = ev_addr_q[wi];
            last_wr_data = ev_data_q[wi];
        end
        if (rd_exp && ri >= 0) check("rd_addr", 32'(ev_addr_q[ri]), 32'(ra));
        if (wr_exp) mem[ra] = wd;
        last_n_wr = n_wr;
        last_n_rd = n_rd;
    endtask

    initial begin
        int          pre_n, sel;
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        logic [15:0] wd;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[3] = 16'h1234;
        last_wr_addr = 5'h00;
        last_wr_data = 16'h0000;

        repeat (4) @(negedge clk_200m);
        check("rst_oen", 32'(mdio_oen), 32'd1);
        check("rst_out", 32'(mdio_out), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
        rstn_200m = 1'b1;
        repeat (4) @(negedge clk_200m);

        frame(32, 2'b01, 5'h01, 5'h0A, 16'hA5C3, -1);
        check("lit_wr_addr", 32'(last_wr_addr), 32'h0A);
        check("lit_wr_data", 32'(last_wr_data), 32'hA5C3);
        frame(32, 2'b10, 5'h01, 5'h03, 16'h0000, -1);
        check("lit_rd_data", 32'(rd_word), 32'h1234);
        check("lit_rd_count", 32'(last_n_rd), 32'd1);

        frame(32, 2'b01, 5'h02, 5'h05, 16'hBEEF, -1);
        check("lit_other_phy_wr", 32'(last_n_wr), 32'd0);
        frame(32, 2'b10, 5'h02, 5'h05, 16'h0000, -1);
        check("lit_other_phy_rd", 32'(last_n_rd), 32'd0);

        frame(31, 2'b01, 5'h01, 5'h07, 16'h0F0F, -1);
        check("lit_short_pre", 32'(last_n_wr), 32'd0);
        frame(32, 2'b01, 5'h01, 5'h07, 16'h0F0F, -1);
        check("lit_retry_wr", 32'(last_wr_data), 32'h0F0F);

        frame(32, 2'b00, 5'h01, 5'h08, 16'h1111, -1);
        frame(32, 2'b11, 5'h01, 5'h08, 16'h2222, -1);
        frame(32, 2'b01, 5'h01, 5'h08, 16'h3C3C, -1);
        check("lit_after_badop", 32'(last_wr_data), 32'h3C3C);

        frame(32, 2'b10, 5'h01, 5'h03, 16'h0000, 20);
        repeat (5) @(negedge clk_200m);
        frame(32, 2'b10, 5'h01, 5'h0A, 16'h0000, -1);
        check("lit_rd_after_rst", 32'(rd_word), 32'hA5C3);

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 2));
            pre_n = (sel == 0) ? PRE - 1 : (sel == 1) ? PRE : PRE + int'($urandom_range(1, 8));
            op  = 2'($urandom);
            phy = ($urandom_range(0, 2) == 0) ? 5'($urandom) : PHY;
            ra  = 5'($urandom);
            wd  = 16'($urandom);
            frame(pre_n, op, phy, ra, wd, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_slave_if.md
Name: mdio_slave_if

Overview:
- IEEE 802.3 Clause 22 MDIO slave for the control subsystem. It decodes MDC/MDIO frames coming from the iopad MDC/MDIO nets and produces single-cycle register read/write strobes on the regfile bus.
- For reads it returns data on mdio_out/mdio_oen back to the MDIO pad.
- Runs entirely in the 200 MHz domain: MDC is oversampled, not used as a clock.

Parameters:
PHY_ADDR, 5'h01, PHYAD value this slave answers to; any other PHYAD is ignored.
PRE_LEN, 32, minimum number of consecutive sampled '1' bits required before ST is accepted (range 1..63).

Ports:
clk_200m  input  1  system clock, 200 MHz
rstn_200m  input  1  asynchronous active-low reset
mdc  input  1  MDIO management clock from pad, asynchronous, at most 25 MHz
mdio_in  input  1  MDIO data from pad, asynchronous
mdio_out  output  1  MDIO data driven to pad
mdio_oen  output  1  pad output enable, active low (0 = slave drives)
reg_addr  output  5  REGAD of the current frame
reg_wdata  output  16  write data
reg_wr_en  output  1  one-cycle write strobe
reg_rd_en  output  1  one-cycle read strobe
reg_rdata  input  16  read data, valid exactly 1 clk_200m cycle after reg_rd_en

Behaviour:
- Clock and reset: single clock clk_200m; asynchronous active-low reset rstn_200m. Deasserting rstn_200m is synchronised outside this block.
- Reset values:
  - mdio_out=0, mdio_oen=1, reg_wr_en=0, reg_rd_en=0
  - reg_addr=0, reg_wdata=0
  - state=IDLE, all counters and shift registers 0
- Input sampling:
  - mdc and mdio_in each pass through a 2-flop synchroniser.
  - A rising edge ("rise") is detected when the synchronised mdc is 1 and its previous value was 0.
  - The synchronised mdio_in is sampled in the cycle rise is detected.
  - Rise detect latency from the pad is 3 clk_200m cycles.
  - The MDC high and low phases are each at least 4 clk_200m cycles.
- All state changes below happen only on rise cycles, except the read-data latch.
- State machine (bit = sampled mdio on rise):
  - IDLE:
    - bit=1 increments ones_cnt, saturating at 63.
    - bit=0 with ones_cnt>=PRE_LEN goes to ST.
    - bit=0 with ones_cnt<PRE_LEN clears ones_cnt.
  - ST: bit=1 goes to OP. bit=0 goes to IDLE and clears ones_cnt.
  - OP: collects 2 bits.
    - 01 = write, 10 = read; either goes to PHYAD.
    - 00 or 11 goes to IDLE.
  - PHYAD: collects 5 bits, MSB first. match is set when the value equals PHY_ADDR.
  - REGAD: collects 5 bits, MSB first. On the 5th bit reg_addr is loaded and the block goes to TA.
    - If read and match: reg_rd_en pulses for 1 cycle in the cycle after that rise.
    - The following cycle, reg_rdata is latched into a 16-bit shift register.
  - TA: 2 bits.
    - Read and match: on the first TA rise, drive mdio_oen=0 and mdio_out=0. The drive stays through the second TA bit.
    - Write: TA values are ignored.
  - DATA: 16 bits.
    - Read and match: on each rise starting from the second TA rise, mdio_out takes the next bit, D15 first. After the D0 bit-time rise (the rise ending the frame), mdio_oen=1 and mdio_out=0.
    - Write: shift in the 16 bits MSB first. After the 16th bit, if match, load reg_wdata and pulse reg_wr_en for 1 cycle.
    - In both cases the block then goes to IDLE with ones_cnt=0.
- Non-matching PHYAD: the frame is still tracked to its end. No strobes are issued and mdio_oen stays 1.
- Preamble after a frame: back-to-back frames need a fresh PRE_LEN preamble counted in IDLE.
- Strobes: reg_wr_en and reg_rd_en are never asserted in the same cycle. Each asserts at most once per frame.
- Asynchronous reset mid-frame: all outputs return to reset values immediately, which releases the bus (mdio_oen=1). The next frame requires a full preamble.
- Read turnaround and data: mdio_out changes about 3 clk_200m cycles after the MDC rising edge and is stable for the master's next rising-edge sample.

Test Plan:
- Write PHYAD=1, REGAD=5'h0A, data 16'hA5C3 with 32-bit preamble -> a single reg_wr_en pulse with reg_addr=0x0A and reg_wdata=0xA5C3; mdio_oen stays 1 throughout.
- Read PHYAD=1, REGAD=5'h03 with reg_rdata=16'h1234 returned one cycle after reg_rd_en -> a single reg_rd_en pulse; mdio_oen=0 from TA1 through D0; master samples TA2=0 then data 0x1234; mdio_oen=1 after the frame.
- Write to PHYAD=2 -> no reg_wr_en; read to PHYAD=2 -> no reg_rd_en and mdio_oen stays 1.
- Preamble of 31 ones, then ST, then a write -> ignored with no strobes. An immediate retry with 32 ones is accepted.
- Opcode 00 or 11 after a valid preamble and ST -> return to IDLE with no strobes. A following valid write is decoded correctly.
- Assert rstn_200m during DATA of a read -> mdio_oen goes to 1 at once. After release, the next valid read returns correct data.
